// File: rtl/hilo_acc_bank.sv
// HI/LO special-register bank with per-context pairs, write bypass and a
// two-cycle split-carry MADD/MSUB pipeline (LO first, HI one edge later).
module hilo_acc_bank #(
  parameter int DATA_W  = 32,
  parameter int NUM_CTX = 2,
  localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [CTX_W-1:0]  md_ctx,
  input  logic [1:0]        md_op,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  input  logic              mt_hi_we,
  input  logic              mt_lo_we,
  input  logic [CTX_W-1:0]  mt_ctx,
  input  logic [DATA_W-1:0] mt_data,
  input  logic [CTX_W-1:0]  rd_ctx,
  output logic [DATA_W-1:0] hi_rd,
  output logic [DATA_W-1:0] lo_rd,
  output logic              rd_valid
);

  typedef enum logic {IDLE, ACC_HI} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] hi_q [NUM_CTX];
  logic [DATA_W-1:0] lo_q [NUM_CTX];

  logic [CTX_W-1:0]  pend_ctx;
  logic              pend_ok;
  logic              pend_sub;
  logic              pend_cb;
  logic [DATA_W-1:0] pend_hi;

  logic              accept;
  logic              md_acc_op;
  logic              md_wr;
  logic              md_acc;
  logic              md_ok;
  logic              rd_ok;
  logic              in_acc;
  logic [DATA_W-1:0] lo_cur;
  logic [DATA_W:0]   acc_lo;
  logic [DATA_W-1:0] hi_cur;
  logic [DATA_W-1:0] hi_fin;

  function automatic logic ctx_ok(input logic [CTX_W-1:0] c);
    return 32'(c) < 32'(NUM_CTX);
  endfunction

  assign md_ready  = (state_q == IDLE);
  assign accept    = md_valid & md_ready;
  assign md_acc_op = md_op[0] ^ md_op[1];
  assign md_wr     = accept & ~md_acc_op;
  assign md_acc    = accept & md_acc_op;
  assign md_ok     = ctx_ok(md_ctx);
  assign rd_ok     = ctx_ok(rd_ctx);
  assign in_acc    = (state_q == ACC_HI);

  // Extra top bit of the LO result is the carry (add) or borrow (sub).
  assign lo_cur = md_ok ? lo_q[md_ctx] : '0;
  assign acc_lo = md_op[1] ? {1'b0, lo_cur} - {1'b0, md_lo}
                           : {1'b0, lo_cur} + {1'b0, md_lo};

  assign hi_cur = pend_ok ? hi_q[pend_ctx] : '0;
  assign hi_fin = pend_sub ? hi_cur - pend_hi - DATA_W'(pend_cb)
                           : hi_cur + pend_hi + DATA_W'(pend_cb);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (md_acc) state_d = ACC_HI;
      ACC_HI:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_ctx <= '0;
      pend_ok  <= 1'b0;
      pend_sub <= 1'b0;
      pend_cb  <= 1'b0;
      pend_hi  <= '0;
    end else begin
      state_q <= state_d;
      if (md_acc) begin
        pend_ctx <= md_ctx;
        pend_ok  <= md_ok;
        pend_sub <= md_op[1];
        pend_cb  <= acc_lo[DATA_W];
        pend_hi  <= md_hi;
      end
    end
  end

  // The younger MTHI overrides a pending HI update of the same context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        hi_q[i] <= '0;
        lo_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (md_wr && md_ctx == CTX_W'(i))
          hi_q[i] <= md_hi;
        else if (mt_hi_we && mt_ctx == CTX_W'(i))
          hi_q[i] <= mt_data;
        else if (in_acc && pend_ctx == CTX_W'(i))
          hi_q[i] <= hi_fin;

        if (md_wr && md_ctx == CTX_W'(i))
          lo_q[i] <= md_lo;
        else if (md_acc && md_ctx == CTX_W'(i))
          lo_q[i] <= acc_lo[DATA_W-1:0];
        else if (mt_lo_we && mt_ctx == CTX_W'(i))
          lo_q[i] <= mt_data;
      end
    end
  end

  always_comb begin
    hi_rd    = '0;
    lo_rd    = '0;
    rd_valid = 1'b1;
    if (rd_ok) begin
      hi_rd = hi_q[rd_ctx];
      lo_rd = lo_q[rd_ctx];
      if (in_acc && pend_ctx == rd_ctx)
        hi_rd = hi_fin;
      if (mt_hi_we && mt_ctx == rd_ctx)
        hi_rd = mt_data;
      if (mt_lo_we && mt_ctx == rd_ctx)
        lo_rd = mt_data;
      if (md_acc && md_ctx == rd_ctx) begin
        lo_rd    = acc_lo[DATA_W-1:0];
        rd_valid = 1'b0;
      end
      if (md_wr && md_ctx == rd_ctx) begin
        hi_rd = md_hi;
        lo_rd = md_lo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_acc_bank.sv
// Directed bench for hilo_acc_bank: writes, bypass, MADD/MSUB, MT
// conflicts and reset, each step checked against hand-computed values.
module tb_hilo_acc_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_valid;
  logic        md_ready;
  logic [0:0]  md_ctx;
  logic [1:0]  md_op;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        mt_hi_we;
  logic        mt_lo_we;
  logic [0:0]  mt_ctx;
  logic [31:0] mt_data;
  logic [0:0]  rd_ctx;
  logic [31:0] hi_rd;
  logic [31:0] lo_rd;
  logic        rd_valid;

  int nvec = 0;
  int nerr = 0;

  hilo_acc_bank #(.DATA_W(32), .NUM_CTX(2)) dut (
    .clk(clk), .rst(rst),
    .md_valid(md_valid), .md_ready(md_ready),
    .md_ctx(md_ctx), .md_op(md_op),
    .md_hi(md_hi), .md_lo(md_lo),
    .mt_hi_we(mt_hi_we), .mt_lo_we(mt_lo_we),
    .mt_ctx(mt_ctx), .mt_data(mt_data),
    .rd_ctx(rd_ctx), .hi_rd(hi_rd), .lo_rd(lo_rd),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    md_valid = 1'b0;
    md_ctx   = '0;
    md_op    = 2'b00;
    md_hi    = '0;
    md_lo    = '0;
    mt_hi_we = 1'b0;
    mt_lo_we = 1'b0;
    mt_ctx   = '0;
    mt_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic md(input logic c, input logic [1:0] op,
                    input logic [31:0] h, input logic [31:0] l);
    md_valid = 1'b1;
    md_ctx   = c;
    md_op    = op;
    md_hi    = h;
    md_lo    = l;
  endtask

  task automatic rd(input string tag, input logic c,
                    input logic [31:0] eh, input logic [31:0] el);
    rd_ctx = c;
    #1;
    chk({tag, ".hi"}, hi_rd, eh);
    chk({tag, ".lo"}, lo_rd, el);
  endtask

  initial begin
    idle();
    rd_ctx = '0;
    rst    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    rd("rst0", 1'b0, 32'h0, 32'h0);
    rd("rst1", 1'b1, 32'h0, 32'h0);
    chk("rst.ready", 32'(md_ready), 32'd1);
    chk("rst.valid", 32'(rd_valid), 32'd1);
    tick();

    // Write with same-cycle bypass
    md(1'b0, 2'b00, 32'h12345678, 32'h9ABCDEF0);
    rd("wr.byp", 1'b0, 32'h12345678, 32'h9ABCDEF0);
    chk("wr.valid", 32'(rd_valid), 32'd1);
    rd("wr.other", 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    rd("wr.store", 1'b0, 32'h12345678, 32'h9ABCDEF0);
    tick();

    // op 11 write beats a same-ctx MTHI
    md(1'b1, 2'b11, 32'hAAAA0000, 32'h0000BBBB);
    mt_hi_we = 1'b1;
    mt_ctx   = 1'b1;
    mt_data  = 32'h11111111;
    rd("wr11.byp", 1'b1, 32'hAAAA0000, 32'h0000BBBB);
    tick();
    idle();
    rd("wr11.store", 1'b1, 32'hAAAA0000, 32'h0000BBBB);
    tick();

    // Mid-run asynchronous reset
    #2 rst = 1'b0;
    rd("midrst0", 1'b0, 32'h0, 32'h0);
    rd("midrst1", 1'b1, 32'h0, 32'h0);
    chk("midrst.ready", 32'(md_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();

    // MADD with carry into HI
    md(1'b0, 2'b00, 32'h0, 32'hFFFFFFFF);
    tick();
    md(1'b0, 2'b01, 32'h0, 32'h00000001);
    rd("madd.acc", 1'b0, 32'h0, 32'h0);
    chk("madd.acc.valid", 32'(rd_valid), 32'd0);
    chk("madd.acc.ready", 32'(md_ready), 32'd1);
    tick();
    rd("madd.e1", 1'b0, 32'h00000001, 32'h0);
    chk("madd.e1.ready", 32'(md_ready), 32'd0);
    chk("madd.e1.valid", 32'(rd_valid), 32'd1);
    tick();
    idle();
    rd("madd.e2", 1'b0, 32'h00000001, 32'h0);
    chk("madd.e2.ready", 32'(md_ready), 32'd1);
    tick();

    // MSUB with borrow out of LO
    md(1'b1, 2'b00, 32'h00000001, 32'h0);
    tick();
    md(1'b1, 2'b10, 32'h0, 32'h00000001);
    rd("msub.acc", 1'b1, 32'h00000001, 32'hFFFFFFFF);
    tick();
    idle();
    tick();
    rd("msub.fin", 1'b1, 32'h0, 32'hFFFFFFFF);
    tick();

    // MTHI in ACC_HI beats pending HI; ctx0 is 1:0 here
    md(1'b0, 2'b01, 32'h00000005, 32'h00000003);
    tick();
    idle();
    mt_hi_we = 1'b1;
    mt_ctx   = 1'b0;
    mt_data  = 32'hDEADBEEF;
    rd("mtc.byp", 1'b0, 32'hDEADBEEF, 32'h00000003);
    tick();
    // Accept right after ACC_HI; uses committed HI, carry out of LO
    idle();
    md(1'b0, 2'b01, 32'h00000001, 32'hFFFFFFFE);
    rd("mtc.fin", 1'b0, 32'hDEADBEEF, 32'h00000001);
    chk("b2b.ready", 32'(md_ready), 32'd1);
    tick();
    idle();
    mt_lo_we = 1'b1;
    mt_ctx   = 1'b1;
    mt_data  = 32'hCAFEF00D;
    rd("oth.byp", 1'b1, 32'h0, 32'hCAFEF00D);
    tick();
    idle();
    rd("b2b.fin", 1'b0, 32'hDEADBEF1, 32'h00000001);
    rd("oth.fin", 1'b1, 32'h0, 32'hCAFEF00D);
    tick();

    // Reset during ACC_HI abandons the HI update
    md(1'b0, 2'b01, 32'h00000007, 32'h00000001);
    tick();
    idle();
    chk("racc.ready0", 32'(md_ready), 32'd0);
    rst = 1'b0;
    rd("racc.now0", 1'b0, 32'h0, 32'h0);
    chk("racc.ready1", 32'(md_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rd("racc.fin0", 1'b0, 32'h0, 32'h0);
    rd("racc.fin1", 1'b1, 32'h0, 32'h0);
    chk("racc.ready2", 32'(md_ready), 32'd1);
    chk("racc.valid", 32'(rd_valid), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hilo_acc_bank.md
# hilo_acc_bank

Parametrised HI/LO special-register bank for the EXE/WB boundary. It holds `NUM_CTX` independent HI/LO pairs of `DATA_W` bits each, one pair per thread or shadow context. It accepts multiply/divide results through a valid/ready handshake. It performs MADD/MSUB-class accumulation as a two-cycle split-carry pipeline, so the full 2×`DATA_W` adder is not on one path. It also services MTHI/MTLO writes and provides same-cycle read bypass with a per-context validity flag for hazard stalls.

## Interface
- `DATA_W`, 32, width of each of HI and LO.
- `NUM_CTX`, 2, number of HI/LO pairs; `CTX_W = max(1, $clog2(NUM_CTX))`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `md_valid` in 1: a multiply/divide result is presented.
- `md_ready` out 1: bank can accept; equals (state == IDLE).
- `md_ctx` in `CTX_W`: target context of the result.
- `md_op` in 2: 00 write, 01 accumulate-add, 10 accumulate-sub, 11 write.
- `md_hi`, `md_lo` in `DATA_W`: result halves.
- `mt_hi_we`, `mt_lo_we` in 1: MTHI/MTLO write enables.
- `mt_ctx` in `CTX_W`: MTHI/MTLO target context.
- `mt_data` in `DATA_W`: MTHI/MTLO data.
- `rd_ctx` in `CTX_W`: read context.
- `hi_rd`, `lo_rd` out `DATA_W`: bypassed HI/LO of `rd_ctx`.
- `rd_valid` out 1: `hi_rd`/`lo_rd` are architecturally final.

## Operation
- Accept condition: `md_valid & md_ready`. A context index ≥ `NUM_CTX` is ignored on write and reads return 0 with `rd_valid` = 1.
- Write ops (00/11): `{HI,LO}[md_ctx]` ← `{md_hi,md_lo}` at the next edge. Stays in IDLE.
- Accumulate ops (01/10) use the FSM IDLE → ACC_HI → IDLE.
  - Accept cycle (IDLE): `LO ← LO ± md_lo`. Latch the carry (add) or borrow (sub) as `cb`, plus `md_hi`, op, and ctx. Go to ACC_HI.
  - ACC_HI: add gives `HI ← HI + md_hi_q + cb`; sub gives `HI ← HI − md_hi_q − cb`. Return to IDLE. `md_ready` = 0.
  - All arithmetic is modulo 2^`DATA_W` per half. The overflow of the HI half is discarded.
- MT writes are applied every cycle, independent of the FSM.
- Same-cycle same-ctx same-register conflict between an accepted md write and an mt write: the md write wins.
- ACC_HI with `mt_hi_we` to the pending ctx: the mt write wins and the pending HI update is discarded, because the MT is the younger instruction.
- An mt write to LO during ACC_HI is applied normally.
- Writes to other contexts proceed during ACC_HI.
- Read bypass (combinational, for `rd_ctx`), highest priority first:
  1. Accepted md write this cycle: returns `md_hi`/`md_lo`.
  2. Accumulate accept cycle, same ctx: `lo_rd` = new LO, `rd_valid` = 0.
  3. ACC_HI, same ctx: `hi_rd` = computed final HI, or `mt_data` if `mt_hi_we`. `rd_valid` = 1.
  4. mt write this cycle: returns `mt_data`.
  5. Otherwise: the stored value.
- `rd_valid` = 1 in every case except case 2.

## Timing
- Reset (asynchronous assert) forces:
  - all HI and LO to 0;
  - state to IDLE, so `md_ready` = 1;
  - `rd_valid` = 1;
  - `hi_rd`/`lo_rd` to 0, absent same-cycle bypass.
- Reset during ACC_HI abandons the accumulate with no partial HI update.
- Write latency: 1 edge to storage, 0 cycles to the read bypass.
- Accumulate latency: LO is updated at edge 1 and HI at edge 2. Throughput is one accumulate per 2 cycles. `md_ready` is low for exactly 1 cycle.
- A new md result may be accepted in the cycle after ACC_HI.
- Back-to-back accumulates to the same ctx use the committed HI.
- `md_valid` held while `md_ready` = 0 must keep its payload stable. The bank does not latch a rejected transfer.

## Test plan
- **Reset:** assert `rst` = 0 mid-run, then release. Expect `hi_rd` = `lo_rd` = 0 for both contexts, `md_ready` = 1, `rd_valid` = 1.
- **Write with bypass:**
  - Stimulus: ctx0, op 00, hi = 0x12345678, lo = 0x9ABCDEF0.
  - Expect `hi_rd`/`lo_rd` to show these values in the same cycle with `rd_ctx` = 0, and stored thereafter.
  - Expect ctx1 to still read 0.
- **MADD with carry:**
  - Stimulus: ctx0 preset to HI:LO = 0x00000000:0xFFFFFFFF, then op 01 with 0x00000000:0x00000001.
  - Expect after edge 1: LO = 0 and `rd_valid` = 0 in the accept cycle.
  - Expect after edge 2: HI = 0x00000001 and `md_ready` low for 1 cycle.
- **MSUB with borrow:**
  - Stimulus: ctx1 preset to 0x00000001:0x00000000, then op 10 with 0x00000000:0x00000001.
  - Expect the final value 0x00000000:0xFFFFFFFF.
- **MT conflict during ACC_HI:**
  - Stimulus: ctx0 accumulate in flight, with `mt_hi_we` to ctx0 and data 0xDEADBEEF in ACC_HI.
  - Expect final HI = 0xDEADBEEF.
  - Expect a simultaneous `mt_lo_we` to ctx1 with 0xCAFEF00D to land in ctx1 LO.
- **Reset in ACC_HI:** start op 01 on ctx0, then drop `rst` during ACC_HI. Expect all registers 0, state IDLE, and `md_ready` = 1 immediately after reset.
